// File: rtl/regfile_write_arbiter.sv
// Register file write arbiter: two requesters (A = ALU, B = load) each own a
// one-entry holding slot; one slot is granted per cycle and its entry goes
// through a registered output stage to the register file write port.
// Writes to register 0 are dropped at grant time.
// Build option: define REGFILE_ARB_RR_EN for round-robin arbitration on
// conflicts; otherwise B (load) has fixed priority over A.
module regfile_write_arbiter #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 5,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  ValidA,
  input  logic [ADDR_WIDTH-1:0] AddrA,
  input  logic [DATA_WIDTH-1:0] DataA,
  output logic                  ReadyA,
  input  logic                  ValidB,
  input  logic [ADDR_WIDTH-1:0] AddrB,
  input  logic [DATA_WIDTH-1:0] DataB,
  output logic                  ReadyB,
  output logic                  RegWrite,
  output logic [ADDR_WIDTH-1:0] WriteRegister,
  output logic [DATA_WIDTH-1:0] WriteData,
  output logic                  Busy,
  output logic [CNT_WIDTH-1:0]  StallCount
);

  // Index 0 is requester A, index 1 is requester B.
  logic [1:0]            valid_in;
  logic [ADDR_WIDTH-1:0] addr_in [2];
  logic [DATA_WIDTH-1:0] data_in [2];

  logic [1:0]            full_reg;
  logic [ADDR_WIDTH-1:0] addr_reg [2];
  logic [DATA_WIDTH-1:0] data_reg [2];

  logic [1:0]            grant;
  logic [1:0]            ready;
  logic                  conflict;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_data;
  logic                  write_ok;

  logic                  reg_write_reg;
  logic [ADDR_WIDTH-1:0] write_register_reg;
  logic [DATA_WIDTH-1:0] write_data_reg;
  logic [CNT_WIDTH-1:0]  stall_count_reg;

  assign valid_in   = {ValidB, ValidA};
  assign addr_in[0] = AddrA;
  assign addr_in[1] = AddrB;
  assign data_in[0] = DataA;
  assign data_in[1] = DataB;

  assign conflict = full_reg[0] & full_reg[1];

`ifdef REGFILE_ARB_RR_EN
  // High when A should win the next conflict; flips after every grant.
  logic prefer_a_reg;

  // Round-robin grant: on conflict pick the slot not granted most recently.
  always_comb begin
    grant = full_reg;
    if (conflict) begin
      grant = prefer_a_reg ? 2'b01 : 2'b10;
    end
  end

  // Pointer tracks the most recent grant; reset favours A.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      prefer_a_reg <= 1'b1;
    end else if (grant[0]) begin
      prefer_a_reg <= 1'b0;
    end else if (grant[1]) begin
      prefer_a_reg <= 1'b1;
    end
  end
`else
  // Fixed priority grant: load writeback (B) always beats ALU (A).
  always_comb begin
    grant = 2'b00;
    if (full_reg[1]) begin
      grant = 2'b10;
    end else if (full_reg[0]) begin
      grant = 2'b01;
    end
  end
`endif

  // Mux the granted slot; an entry targeting register 0 is simply discarded.
  always_comb begin
    sel_addr = grant[1] ? addr_reg[1] : addr_reg[0];
    sel_data = grant[1] ? data_reg[1] : data_reg[0];
    write_ok = (|grant) && (sel_addr != '0);
  end

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_slot
      // A slot can take a request when empty or when it is being drained now.
      assign ready[gi] = ~Reset & (~full_reg[gi] | grant[gi]);

      // Holding slot: refill wins over drain so back-to-back requests stream.
      always_ff @(posedge Clock) begin
        if (Reset) begin
          full_reg[gi] <= 1'b0;
        end else if (valid_in[gi] && ready[gi]) begin
          full_reg[gi] <= 1'b1;
          addr_reg[gi] <= addr_in[gi];
          data_reg[gi] <= data_in[gi];
        end else if (grant[gi]) begin
          full_reg[gi] <= 1'b0;
        end
      end
    end
  endgenerate

  // Output stage: one-cycle pulse per real write, index/data hold otherwise.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      reg_write_reg      <= 1'b0;
      write_register_reg <= '0;
      write_data_reg     <= '0;
    end else begin
      reg_write_reg <= write_ok;
      if (write_ok) begin
        write_register_reg <= sel_addr;
        write_data_reg     <= sel_data;
      end
    end
  end

  // Count cycles in which a full slot lost arbitration, sticking at all-ones.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      stall_count_reg <= '0;
    end else if (conflict && (stall_count_reg != {CNT_WIDTH{1'b1}})) begin
      stall_count_reg <= stall_count_reg + 1'b1;
    end
  end

  assign ReadyA        = ready[0];
  assign ReadyB        = ready[1];
  assign RegWrite      = reg_write_reg;
  assign WriteRegister = write_register_reg;
  assign WriteData     = write_data_reg;
  assign Busy          = (|full_reg) | reg_write_reg;
  assign StallCount    = stall_count_reg;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Scoreboard bench for regfile_write_arbiter: a reference model issues the
// expected register writes into a queue, a negedge monitor pops and compares.
// A second instance with a 2-bit stall counter exercises saturation.
module tb_regfile_write_arbiter;
  localparam int DW = 64;
  localparam int AW = 5;
  localparam int STALL_MAX = 65535;

  logic Clock = 1'b0;
  always #5 Clock = ~Clock;

  logic          Reset = 1'b1;
  logic          ValidA = 1'b0, ValidB = 1'b0;
  logic [AW-1:0] AddrA = '0, AddrB = '0;
  logic [DW-1:0] DataA = '0, DataB = '0;

  logic          ReadyA, ReadyB, RegWrite, Busy;
  logic [AW-1:0] WriteRegister;
  logic [DW-1:0] WriteData;
  logic [15:0]   StallCount;

  logic          s_ReadyA, s_ReadyB, s_RegWrite, s_Busy;
  logic [AW-1:0] s_WriteRegister;
  logic [DW-1:0] s_WriteData;
  logic [1:0]    s_StallCount;

  regfile_write_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CNT_WIDTH(16)) dut (
    .Clock(Clock), .Reset(Reset),
    .ValidA(ValidA), .AddrA(AddrA), .DataA(DataA), .ReadyA(ReadyA),
    .ValidB(ValidB), .AddrB(AddrB), .DataB(DataB), .ReadyB(ReadyB),
    .RegWrite(RegWrite), .WriteRegister(WriteRegister), .WriteData(WriteData),
    .Busy(Busy), .StallCount(StallCount)
  );

  regfile_write_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CNT_WIDTH(2)) dut_small (
    .Clock(Clock), .Reset(Reset),
    .ValidA(ValidA), .AddrA(AddrA), .DataA(DataA), .ReadyA(s_ReadyA),
    .ValidB(ValidB), .AddrB(AddrB), .DataB(DataB), .ReadyB(s_ReadyB),
    .RegWrite(s_RegWrite), .WriteRegister(s_WriteRegister), .WriteData(s_WriteData),
    .Busy(s_Busy), .StallCount(s_StallCount)
  );

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    int            cyc;
  } exp_t;

  exp_t sb[$];
  int compared = 0;
  int mismatched = 0;
  int cyc = 0;

  // Reference model state: one entry per requester plus the visible outputs.
  bit            m_full [2] = '{0, 0};
  logic [AW-1:0] m_addr [2] = '{'0, '0};
  logic [DW-1:0] m_data [2] = '{'0, '0};
  bit            m_last_b = 1'b1;
  int            m_stall = 0;
  bit            m_out = 1'b0;
  logic [AW-1:0] m_wreg = '0;
  logic [DW-1:0] m_wdata = '0;

  // Which held entry wins this cycle (-1 = none).
  function automatic int m_winner();
    if (m_full[0] && m_full[1]) begin
`ifdef REGFILE_ARB_RR_EN
      return m_last_b ? 0 : 1;
`else
      return 1;
`endif
    end
    if (m_full[0]) return 0;
    if (m_full[1]) return 1;
    return -1;
  endfunction

  function automatic bit m_ready(int s);
    return !Reset && (!m_full[s] || m_winner() == s);
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  // Reference model: advance one cycle per rising edge.
  always @(posedge Clock) begin
    int w;
    bit hs0, hs1;
    w   = m_winner();
    hs0 = ValidA && m_ready(0);
    hs1 = ValidB && m_ready(1);
    cyc++;
    if (Reset) begin
      m_full   = '{0, 0};
      m_last_b = 1'b1;
      m_stall  = 0;
      m_out    = 1'b0;
      m_wreg   = '0;
      m_wdata  = '0;
    end else begin
      if (m_full[0] && m_full[1]) m_stall = (m_stall < STALL_MAX) ? m_stall + 1 : STALL_MAX;
      m_out = 1'b0;
      if (w >= 0) begin
        m_last_b = (w == 1);
        if (m_addr[w] != 0) begin
          sb.push_back('{addr: m_addr[w], data: m_data[w], cyc: cyc});
          m_out   = 1'b1;
          m_wreg  = m_addr[w];
          m_wdata = m_data[w];
        end
        m_full[w] = 1'b0;
      end
      if (hs0) begin m_full[0] = 1'b1; m_addr[0] = AddrA; m_data[0] = DataA; end
      if (hs1) begin m_full[1] = 1'b1; m_addr[1] = AddrB; m_data[1] = DataB; end
    end
  end

  // Monitor: compare DUT outputs mid-cycle against the model and scoreboard.
  always @(negedge Clock) begin
    exp_t e;
    chk("ReadyA", 64'(ReadyA), 64'(m_ready(0)));
    chk("ReadyB", 64'(ReadyB), 64'(m_ready(1)));
    chk("Busy", 64'(Busy), 64'(m_full[0] | m_full[1] | m_out));
    chk("StallCount", 64'(StallCount), 64'(m_stall));
    chk("StallCount_sat2", 64'(s_StallCount), 64'((m_stall > 3) ? 3 : m_stall));
    chk("WriteRegister_hold", 64'(WriteRegister), 64'(m_wreg));
    chk("WriteData_hold", 64'(WriteData), 64'(m_wdata));
    if (RegWrite === 1'b1) begin
      if (sb.size() == 0) begin
        chk("spurious_RegWrite", 64'(1), 64'(0));
      end else begin
        e = sb.pop_front();
        chk("write_cycle", 64'(cyc), 64'(e.cyc));
        chk("write_addr", 64'(WriteRegister), 64'(e.addr));
        chk("write_data", WriteData, e.data);
      end
    end else if (sb.size() != 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      chk("missing_RegWrite", 64'(RegWrite), 64'(1));
    end
  end

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic drive(bit va, logic [AW-1:0] aa, logic [DW-1:0] da,
                       bit vb, logic [AW-1:0] ab, logic [DW-1:0] db);
    ValidA = va; AddrA = aa; DataA = da;
    ValidB = vb; AddrB = ab; DataB = db;
  endtask

  task automatic idle(int n);
    drive(0, '0, '0, 0, '0, '0);
    repeat (n) step();
  endtask

  initial begin
    Reset = 1'b1;
    repeat (3) step();
    Reset = 1'b0;

    // Single A write to r5.
    drive(1, 5, 64'h1234, 0, '0, '0);
    step();
    idle(4);

    // Load to x0 must be accepted and dropped.
    drive(0, '0, '0, 1, 0, 64'hFF);
    step();
    idle(4);

    // Same-cycle conflict on r3.
    drive(1, 3, 64'hA, 1, 3, 64'hB);
    step();
    idle(5);

    // Both sides streaming: saturates the 2-bit counter.
    for (int i = 0; i < 12; i++) begin
      drive(1, AW'($urandom_range(1, 31)), {$urandom, $urandom},
            1, AW'($urandom_range(1, 31)), {$urandom, $urandom});
      step();
    end
    idle(4);

    // Reset while both slots hold entries, then a fresh A request.
    drive(1, 7, 64'h77, 1, 9, 64'h99);
    step();
    drive(0, '0, '0, 0, '0, '0);
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    drive(1, 4, 64'hCAFE, 0, '0, '0);
    step();
    idle(4);

    // Randomised traffic with occasional resets and x0 targets.
    for (int i = 0; i < 800; i++) begin
      drive(($urandom_range(0, 99) < 60), AW'($urandom_range(0, 7)), {$urandom, $urandom},
            ($urandom_range(0, 99) < 60), AW'($urandom_range(0, 7)), {$urandom, $urandom});
      Reset = ($urandom_range(0, 99) == 0);
      step();
    end
    Reset = 1'b0;
    idle(10);

    chk("scoreboard_drained", 64'(sb.size()), 64'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
